// File: rtl/ninjakun_arb_pkg.sv
// Shared types for the work-RAM arbiter between the Z80 and the hiscore engine.
package ninjakun_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSING,
        ST_SETTLE,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HS
    } ram_owner_t;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Hands the single-port work RAM to the hiscore engine while the CPU is paused,
// then gives it back. The RAM mux select is a registered owner bit.
module hs_ram_arbiter
    import ninjakun_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int SETTLE = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    input  logic          hs_access,
    input  logic          hs_write,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_grant,
    output logic          pause_req,
    input  logic          paused,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    ram_owner_t       owner;
    ram_owner_t       owner_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hand_over;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= OWN_CPU;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Release always wins over an external resume.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            ST_IDLE: begin
                if (hs_access)
                    state_nxt = ST_PAUSING;
            end
            ST_PAUSING: begin
                if (!hs_access) begin
                    state_nxt = ST_RELEASE;
                end else if (paused) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_SETTLE: begin
                if (!hs_access)
                    state_nxt = ST_RELEASE;
                else if (!paused)
                    state_nxt = ST_PAUSING;
                else if (cnt == '0)
                    state_nxt = ST_GRANT;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            ST_GRANT: begin
                if (!hs_access)
                    state_nxt = ST_RELEASE;
                else if (!paused)
                    state_nxt = ST_PAUSING;
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        owner_nxt = (state_nxt == ST_GRANT) ? OWN_HS : OWN_CPU;
    end

    assign pause_req = (state != ST_IDLE);
    assign hs_grant  = (state == ST_GRANT);
    assign hand_over = (owner_nxt != owner);

    assign cpu_rdata = ram_rdata;
    assign hs_rdata  = ram_rdata;

    // No write may slip through on the last cycle of either owner.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (owner == OWN_HS) begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
            ram_we    = hs_write && (state == ST_GRANT);
        end
        if (hand_over)
            ram_we = 1'b0;
    end

endmodule
